// File: rtl/wb_arbiter.sv
// Writeback arbiter: four per-pipe result FIFOs feeding one registered register-file write port.
// Define WB_ARB_ROUND_ROBIN_EN to swap fixed priority + starvation promotion for a rotating pointer.
module wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_wb_valid,
  input  logic        alu_wb_reg_write,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  output logic        alu_wb_ready,
  input  logic        lsu_wb_valid,
  input  logic        lsu_wb_reg_write,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] lsu_wb_data,
  output logic        lsu_wb_ready,
  input  logic        mul_wb_valid,
  input  logic        mul_wb_reg_write,
  input  logic [4:0]  mul_wb_rd,
  input  logic [31:0] mul_wb_data,
  output logic        mul_wb_ready,
  input  logic        div_wb_valid,
  input  logic        div_wb_reg_write,
  input  logic [4:0]  div_wb_rd,
  input  logic [31:0] div_wb_data,
  output logic        div_wb_ready,
  output logic        wb_wr_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_wr_data,
  output logic        wb_busy
);
  localparam int NSRC = 4;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  // Source index: 0=ALU, 1=LSU, 2=MUL, 3=DIV.
  logic [NSRC-1:0] in_valid, in_reg_write, ready, nonempty, push, pop;
  logic [4:0]      in_rd     [NSRC];
  logic [31:0]     in_data   [NSRC];
  logic [4:0]      head_rd   [NSRC];
  logic [31:0]     head_data [NSRC];

  logic            grant_vld;
  logic [1:0]      grant_idx;
  logic            wb_wr_en_reg;
  logic [4:0]      wb_rd_reg;
  logic [31:0]     wb_wr_data_reg;

  assign in_valid     = {div_wb_valid, mul_wb_valid, lsu_wb_valid, alu_wb_valid};
  assign in_reg_write = {div_wb_reg_write, mul_wb_reg_write, lsu_wb_reg_write, alu_wb_reg_write};
  assign in_rd[0]   = alu_wb_rd;
  assign in_rd[1]   = lsu_wb_rd;
  assign in_rd[2]   = mul_wb_rd;
  assign in_rd[3]   = div_wb_rd;
  assign in_data[0] = alu_wb_data;
  assign in_data[1] = lsu_wb_data;
  assign in_data[2] = mul_wb_data;
  assign in_data[3] = div_wb_data;

  assign {div_wb_ready, mul_wb_ready, lsu_wb_ready, alu_wb_ready} = ready;

`ifndef WB_ARB_ROUND_ROBIN_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [NSRC-1:0] starved;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [36:0]   mem_reg [DEPTH];
      logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [CW-1:0] count_reg;

      // Ready depends only on registered occupancy, so a full buffer never pushes while popping.
      assign nonempty[gi] = (count_reg != '0);
      assign ready[gi]    = (count_reg != CW'(DEPTH)) && !rst;
      assign push[gi]     = in_valid[gi] && ready[gi] && in_reg_write[gi] && (in_rd[gi] != 5'd0);
      assign pop[gi]      = grant_vld && (grant_idx == 2'(gi));
      assign {head_rd[gi], head_data[gi]} = mem_reg[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) begin
            mem_reg[wr_ptr_reg] <= {in_rd[gi], in_data[gi]};
            wr_ptr_reg          <= wr_ptr_reg + 1'b1;
          end
          if (pop[gi])
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          count_reg <= count_reg + CW'(push[gi]) - CW'(pop[gi]);
        end
      end

`ifndef WB_ARB_ROUND_ROBIN_EN
      logic [SW-1:0] wait_reg;
      assign starved[gi] = nonempty[gi] && (wait_reg >= SW'(STARVE_LIMIT));

      always_ff @(posedge clk) begin
        if (rst || !nonempty[gi] || pop[gi])
          wait_reg <= '0;
        else if (wait_reg < SW'(STARVE_LIMIT))
          wait_reg <= wait_reg + 1'b1;
      end
`endif

      always_ff @(posedge clk) begin
        if (!rst)
          assert (!in_valid[gi] || ready[gi]);
      end
    end
  endgenerate

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_reg;

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr_reg <= 2'd0;
    else if (grant_vld)
      rr_ptr_reg <= grant_idx + 2'd1;
  end

  // Walk backwards so the smallest offset from the pointer is the last (winning) assignment.
  always_comb begin
    logic [1:0] idx;
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    idx       = 2'd0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      idx = rr_ptr_reg + 2'(k);
      if (nonempty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end
`else
  // Ascending scans: the highest index (DIV) wins; any starved source overrides the plain scan.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (nonempty[i]) begin
        grant_vld = 1'b1;
        grant_idx = 2'(i);
      end
    end
    if (|starved) begin
      for (int i = 0; i < NSRC; i++) begin
        if (starved[i])
          grant_idx = 2'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wr_en_reg   <= 1'b0;
      wb_rd_reg      <= 5'd0;
      wb_wr_data_reg <= 32'd0;
    end else begin
      wb_wr_en_reg <= grant_vld;
      if (grant_vld) begin
        wb_rd_reg      <= head_rd[grant_idx];
        wb_wr_data_reg <= head_data[grant_idx];
      end
    end
  end

  assign wb_wr_en   = wb_wr_en_reg;
  assign wb_rd      = wb_rd_reg;
  assign wb_wr_data = wb_wr_data_reg;
  assign wb_busy    = (|nonempty) || wb_wr_en_reg;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle, plus directed scenarios
// with hand-computed expectations (write order, latency, backpressure, starvation, reset).
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  v, rw;
  logic [4:0]  rd  [4];
  logic [31:0] dat [4];
  wire  [3:0]  rdy;
  wire         wb_wr_en, wb_busy;
  wire  [4:0]  wb_rd;
  wire  [31:0] wb_wr_data;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(v[0]), .alu_wb_reg_write(rw[0]), .alu_wb_rd(rd[0]), .alu_wb_data(dat[0]), .alu_wb_ready(rdy[0]),
    .lsu_wb_valid(v[1]), .lsu_wb_reg_write(rw[1]), .lsu_wb_rd(rd[1]), .lsu_wb_data(dat[1]), .lsu_wb_ready(rdy[1]),
    .mul_wb_valid(v[2]), .mul_wb_reg_write(rw[2]), .mul_wb_rd(rd[2]), .mul_wb_data(dat[2]), .mul_wb_ready(rdy[2]),
    .div_wb_valid(v[3]), .div_wb_reg_write(rw[3]), .div_wb_rd(rd[3]), .div_wb_data(dat[3]), .div_wb_ready(rdy[3]),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_wr_data(wb_wr_data), .wb_busy(wb_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: per-source queues, wait counts and a round-robin start position.
  logic [36:0] mq [4][$];
  int          wcnt [4];
  int          rrp = 0;
  logic        exp_en = 1'b0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_data = '0;
  bit          started = 1'b0;
  logic [4:0]  wlog [$];

  always @(posedge clk) begin
    int g;
    logic [3:0] acc;
    logic [36:0] e;
    started = 1'b1;
    if (rst) begin
      for (int s = 0; s < 4; s++) begin
        mq[s].delete();
        wcnt[s] = 0;
      end
      rrp = 0; exp_en = 1'b0; exp_rd = '0; exp_data = '0;
    end else begin
      for (int s = 0; s < 4; s++)
        acc[s] = v[s] && (mq[s].size() < DEPTH) && rw[s] && (rd[s] != 5'd0);
      g = -1;
`ifdef WB_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < 4; k++)
        if (g < 0 && mq[(rrp + k) % 4].size() > 0) g = (rrp + k) % 4;
      if (g >= 0) rrp = (g + 1) % 4;
`else
      for (int s = 3; s >= 0; s--)
        if (g < 0 && mq[s].size() > 0 && wcnt[s] >= LIMIT) g = s;
      for (int s = 3; s >= 0; s--)
        if (g < 0 && mq[s].size() > 0) g = s;
      for (int s = 0; s < 4; s++)
        wcnt[s] = (mq[s].size() == 0 || s == g) ? 0 : ((wcnt[s] < LIMIT) ? wcnt[s] + 1 : LIMIT);
`endif
      if (g >= 0) begin
        e = mq[g].pop_front();
        exp_en = 1'b1; exp_rd = e[36:32]; exp_data = e[31:0];
      end else begin
        exp_en = 1'b0;
      end
      for (int s = 0; s < 4; s++)
        if (acc[s]) mq[s].push_back({rd[s], dat[s]});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic any;
      any = 1'b0;
      for (int s = 0; s < 4; s++) begin
        if (mq[s].size() > 0) any = 1'b1;
        check($sformatf("model_ready%0d", s), 32'(rdy[s]), 32'(!rst && (mq[s].size() < DEPTH)));
      end
      check("model_wr_en", 32'(wb_wr_en), 32'(exp_en));
      check("model_rd", 32'(wb_rd), 32'(exp_rd));
      check("model_data", wb_wr_data, exp_data);
      check("model_busy", 32'(wb_busy), 32'(any || exp_en));
      if (wb_wr_en) wlog.push_back(wb_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int k, lk, mk, n7, pos7, dn, ln;
  logic [4:0] exp4 [4];

  initial begin
    rst = 1'b1; v = '0; rw = '0;
    for (int s = 0; s < 4; s++) begin rd[s] = '0; dat[s] = '0; end
    step(); step();
    check("rst_wr_en", 32'(wb_wr_en), 0);
    check("rst_rd", 32'(wb_rd), 0);
    check("rst_data", wb_wr_data, 0);
    check("rst_busy", 32'(wb_busy), 0);
    check("rst_ready", 32'(rdy), 0);
    rst = 1'b0;
    step();
    check("ready_after_rst", 32'(rdy), 32'hF);

    // All four push together.
    wlog.delete();
    for (int s = 0; s < 4; s++) begin
      v[s] = 1'b1; rw[s] = 1'b1; rd[s] = 5'(s + 1); dat[s] = 32'h100 + 32'(s);
    end
    step();
    v = '0;
    repeat (6) step();
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp4[0] = 5'd1; exp4[1] = 5'd2; exp4[2] = 5'd3; exp4[3] = 5'd4;
`else
    exp4[0] = 5'd4; exp4[1] = 5'd3; exp4[2] = 5'd2; exp4[3] = 5'd1;
`endif
    check("all4_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("all4_order%0d", i), (wlog.size() > i) ? 32'(wlog[i]) : 32'hFF, 32'(exp4[i]));

    // Single ALU push: write two cycles later, exactly once.
    v[0] = 1'b1; rw[0] = 1'b1; rd[0] = 5'd5; dat[0] = 32'hDEADBEEF;
    step();
    v[0] = 1'b0;
    check("single_busy_n1", 32'(wb_busy), 1);
    check("single_en_n1", 32'(wb_wr_en), 0);
    step();
    check("single_en_n2", 32'(wb_wr_en), 1);
    check("single_rd_n2", 32'(wb_rd), 5);
    check("single_data_n2", wb_wr_data, 32'hDEADBEEF);
    check("single_busy_n2", 32'(wb_busy), 1);
    step();
    check("single_en_n3", 32'(wb_wr_en), 0);
    check("single_busy_n3", 32'(wb_busy), 0);
    check("single_rd_hold", 32'(wb_rd), 5);

    // Starvation: one ALU entry against a continuous DIV stream.
    wlog.delete();
    v[0] = 1'b1; rw[0] = 1'b1; rd[0] = 5'd7; dat[0] = 32'h7;
    v[3] = 1'b1; rw[3] = 1'b1; rd[3] = 5'd16; dat[3] = 32'd0;
    step();
    v[0] = 1'b0; k = 1;
    for (int c = 0; c < 40 && k < 8; c++) begin
      v[3] = rdy[3]; rd[3] = 5'(16 + k); dat[3] = 32'(k);
      step();
      if (v[3]) k++;
    end
    v[3] = 1'b0;
    repeat (8) step();
    check("starve_div_pushed", k, 8);
    n7 = 0; pos7 = -1; dn = 0;
    for (int i = 0; i < wlog.size(); i++) begin
      if (wlog[i] == 5'd7) begin n7++; pos7 = i; end
      else begin
        check($sformatf("starve_div_order%0d", dn), 32'(wlog[i]), 32'(16 + dn));
        dn++;
      end
    end
    check("starve_alu_once", n7, 1);
    check("starve_div_count", dn, 8);
`ifdef WB_ARB_ROUND_ROBIN_EN
    check("starve_alu_pos", pos7, 1);
`else
    check("starve_alu_pos", pos7, 4);
`endif

    // LSU backpressure while MUL saturates the port.
    wlog.delete();
    lk = 0; mk = 0;
    rw[1] = 1'b1; rw[2] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      v[2] = (mk < 12) && rdy[2]; rd[2] = 5'(20 + (mk % 10)); dat[2] = 32'h200 + 32'(mk);
      v[1] = (lk < 3) && rdy[1];  rd[1] = 5'(10 + lk);        dat[1] = 32'h300 + 32'(lk);
      step();
      if (v[1]) begin
        lk++;
`ifndef WB_ARB_ROUND_ROBIN_EN
        if (lk == 2) check("lsu_full_ready", 32'(rdy[1]), 0);
`endif
      end
      if (v[2]) mk++;
    end
    v = '0;
    repeat (6) step();
    check("lsu_pushed", lk, 3);
    check("mul_pushed", mk, 12);
    ln = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i] >= 5'd10 && wlog[i] <= 5'd12) begin
        check($sformatf("lsu_order%0d", ln), 32'(wlog[i]), 32'(10 + ln));
        ln++;
      end
    check("lsu_written", ln, 3);
    check("total_written", wlog.size(), 15);

    // Discarded pushes: rd=0, then reg_write=0.
    wlog.delete();
    v[0] = 1'b1; rw[0] = 1'b1; rd[0] = 5'd0; dat[0] = 32'h55;
    step();
    rw[0] = 1'b0; rd[0] = 5'd9;
    step();
    v[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("discard_en", 32'(wb_wr_en), 0);
      check("discard_busy", 32'(wb_busy), 0);
      step();
    end
    check("discard_writes", wlog.size(), 0);

    // Reset with two entries buffered.
    v[0] = 1'b1; rw[0] = 1'b1; rd[0] = 5'd3; dat[0] = 32'hA;
    v[1] = 1'b1; rw[1] = 1'b1; rd[1] = 5'd6; dat[1] = 32'hB;
    step();
    v = '0;
    check("pre_rst_busy", 32'(wb_busy), 1);
    rst = 1'b1;
    step();
    check("midrst_wr_en", 32'(wb_wr_en), 0);
    check("midrst_rd", 32'(wb_rd), 0);
    check("midrst_data", wb_wr_data, 0);
    check("midrst_busy", 32'(wb_busy), 0);
    check("midrst_ready", 32'(rdy), 0);
    wlog.delete();
    rst = 1'b0;
    repeat (5) step();
    check("post_rst_ready", 32'(rdy), 32'hF);
    check("post_rst_writes", wlog.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
